// File: rtl/exec_lane_dispatch.sv
// Lane dispatcher: round-robin grant to free executors, in-order retire,
// and a drain-then-broadcast sequence for action-table reconfiguration.
module exec_lane_dispatch #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    output logic [NUM_LANES-1:0] lane_start_o,
    output logic [LANE_W-1:0]    lane_sel_o,
    input  logic [NUM_LANES-1:0] lane_ready_i,
    output logic                 out_valid_o,
    output logic [LANE_W-1:0]    out_lane_o,
    input  logic                 out_ready_i,
    input  logic                 mod_req_i,
    output logic [NUM_LANES-1:0] lane_mod_start_o,
    output logic                 mod_ack_o,
    output logic [LANE_W:0]      inflight_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        MOD,
        ACK
    } state_t;

    state_t state;

    logic [NUM_LANES-1:0] busy;
    logic [NUM_LANES-1:0] done;
    logic [NUM_LANES-1:0] busy_nx;
    logic [NUM_LANES-1:0] done_nx;
    logic [LANE_W-1:0]    rr_ptr;
    logic [LANE_W-1:0]    grant;
    logic [LANE_W-1:0]    wr_ptr;
    logic [LANE_W-1:0]    rd_ptr;
    logic [LANE_W-1:0]    head;
    logic [LANE_W:0]      count;
    logic [LANE_W-1:0]    order_q [NUM_LANES];
    logic                 transfer;
    logic                 retire;
    logic                 head_done;

    function automatic logic [LANE_W:0] popcount(
        input logic [NUM_LANES-1:0] v
    );
        logic [LANE_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + (LANE_W+1)'(v[i]);
        end
        return n;
    endfunction

    // Scan downward so the last hit is the first free lane from rr_ptr.
    always_comb begin
        grant = rr_ptr;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (!busy[rr_ptr + LANE_W'(i)]) begin
                grant = rr_ptr + LANE_W'(i);
            end
        end
    end

    assign pkt_ready_o = !rst && (state == RUN) && !mod_req_i
                         && (busy != '1);
    assign transfer = pkt_valid_i && pkt_ready_o;
    assign retire = out_valid_o && out_ready_i;
    assign lane_start_o = transfer ? (NUM_LANES'(1) << grant) : '0;
    assign lane_sel_o = rst ? '0 : grant;

    assign head = order_q[rd_ptr];
    assign head_done = done[head] || (busy[head] && lane_ready_i[head]);

    always_comb begin
        busy_nx = busy;
        done_nx = done | (busy & lane_ready_i);
        if (transfer) begin
            busy_nx[grant] = 1'b1;
        end
        if (retire) begin
            busy_nx[out_lane_o] = 1'b0;
            done_nx[out_lane_o] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) begin
            order_q[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            busy             <= '0;
            done             <= '0;
            rr_ptr           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            out_valid_o      <= 1'b0;
            out_lane_o       <= '0;
            lane_mod_start_o <= '0;
            mod_ack_o        <= 1'b0;
            inflight_o       <= '0;
        end else begin
            busy       <= busy_nx;
            done       <= done_nx;
            inflight_o <= popcount(busy_nx);
            count      <= count + (LANE_W+1)'(transfer)
                          - (LANE_W+1)'(retire);
            if (transfer) begin
                wr_ptr <= wr_ptr + LANE_W'(1);
                rr_ptr <= grant + LANE_W'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + LANE_W'(1);
            end

            // A retire forces one idle cycle before the next head is offered.
            if (retire) begin
                out_valid_o <= 1'b0;
            end else if (!out_valid_o && count != '0 && head_done) begin
                out_valid_o <= 1'b1;
                out_lane_o  <= head;
            end

            unique case (state)
                RUN: begin
                    if (mod_req_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (busy_nx == '0) begin
                        state            <= MOD;
                        lane_mod_start_o <= '1;
                    end
                end
                MOD: begin
                    state            <= ACK;
                    lane_mod_start_o <= '0;
                    mod_ack_o        <= 1'b1;
                end
                ACK: begin
                    state     <= RUN;
                    mod_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_lane_dispatch.sv
// Directed bench for exec_lane_dispatch: grant order, in-order retire,
// egress stall, reconfiguration drain and mid-flight reset.
module tb_exec_lane_dispatch;

    logic       clk;
    logic       rst;
    logic       pkt_valid_i;
    logic       pkt_ready_o;
    logic [3:0] lane_start_o;
    logic [1:0] lane_sel_o;
    logic [3:0] lane_ready_i;
    logic       out_valid_o;
    logic [1:0] out_lane_o;
    logic       out_ready_i;
    logic       mod_req_i;
    logic [3:0] lane_mod_start_o;
    logic       mod_ack_o;
    logic [2:0] inflight_o;

    int n_chk;
    int n_fail;

    exec_lane_dispatch #(
        .NUM_LANES(4),
        .LANE_W   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pkt_valid_i     (pkt_valid_i),
        .pkt_ready_o     (pkt_ready_o),
        .lane_start_o    (lane_start_o),
        .lane_sel_o      (lane_sel_o),
        .lane_ready_i    (lane_ready_i),
        .out_valid_o     (out_valid_o),
        .out_lane_o      (out_lane_o),
        .out_ready_i     (out_ready_i),
        .mod_req_i       (mod_req_i),
        .lane_mod_start_o(lane_mod_start_o),
        .mod_ack_o       (mod_ack_o),
        .inflight_o      (inflight_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; checks run at posedge+3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        expect_eq({tag, " pkt_ready"}, 32'(pkt_ready_o), 0);
        expect_eq({tag, " lane_start"}, 32'(lane_start_o), 0);
        expect_eq({tag, " lane_sel"}, 32'(lane_sel_o), 0);
        expect_eq({tag, " out_valid"}, 32'(out_valid_o), 0);
        expect_eq({tag, " out_lane"}, 32'(out_lane_o), 0);
        expect_eq({tag, " mod_start"}, 32'(lane_mod_start_o), 0);
        expect_eq({tag, " mod_ack"}, 32'(mod_ack_o), 0);
        expect_eq({tag, " inflight"}, 32'(inflight_o), 0);
    endtask

    task automatic grant_cycle(input string tag, input logic [3:0] exp_start,
                               input logic [1:0] exp_sel);
        pkt_valid_i = 1'b1;
        #2;
        expect_eq({tag, " ready"}, 32'(pkt_ready_o), 1);
        expect_eq({tag, " start"}, 32'(lane_start_o), 32'(exp_start));
        expect_eq({tag, " sel"}, 32'(lane_sel_o), 32'(exp_sel));
        tick();
    endtask

    // Expected out_valid / out_lane for retire sequences (lane 4 = idle).
    int b_seq[8] = '{0, 4, 1, 4, 2, 4, 3, 4};
    int d_seq[8] = '{1, 4, 2, 4, 3, 4, 0, 4};

    task automatic retire_seq(input string tag, input int seq[8]);
        for (int k = 0; k < 8; k++) begin
            #2;
            expect_eq({tag, " valid"}, 32'(out_valid_o),
                      (seq[k] == 4) ? 0 : 1);
            if (seq[k] != 4) begin
                expect_eq({tag, " lane"}, 32'(out_lane_o), 32'(seq[k]));
            end
            tick();
            lane_ready_i = 4'b0000;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        pkt_valid_i = 1'b0;
        lane_ready_i = 4'b0000;
        out_ready_i = 1'b0;
        mod_req_i = 1'b0;
        tick();
        tick();
        #2;
        all_zero("reset");
        tick();
        rst = 1'b0;

        // Four back-to-back packets fill every lane in order.
        grant_cycle("a0", 4'b0001, 2'd0);
        grant_cycle("a1", 4'b0010, 2'd1);
        grant_cycle("a2", 4'b0100, 2'd2);
        grant_cycle("a3", 4'b1000, 2'd3);
        #2;
        expect_eq("a4 ready", 32'(pkt_ready_o), 0);
        expect_eq("a4 start", 32'(lane_start_o), 0);
        tick();
        pkt_valid_i = 1'b0;
        #2;
        expect_eq("a5 inflight", 32'(inflight_o), 4);
        tick();

        // Out-of-order completion still retires 0,1,2,3.
        out_ready_i = 1'b1;
        tick();
        tick();
        lane_ready_i = 4'b0100;
        for (int k = 2; k < 7; k++) begin
            #2;
            expect_eq("b wait valid", 32'(out_valid_o), 0);
            tick();
        end
        lane_ready_i = 4'b1111;
        #2;
        expect_eq("b k7 valid", 32'(out_valid_o), 0);
        tick();
        lane_ready_i = 4'b1111;
        retire_seq("b", b_seq);
        #2;
        expect_eq("b inflight", 32'(inflight_o), 0);
        tick();

        // Egress stall holds head while lanes 1-3 fill behind it.
        grant_cycle("c0", 4'b0001, 2'd0);
        pkt_valid_i = 1'b0;
        lane_ready_i = 4'b0001;
        out_ready_i = 1'b0;
        tick();
        lane_ready_i = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            pkt_valid_i = (k < 3);
            #2;
            expect_eq("c hold valid", 32'(out_valid_o), 1);
            expect_eq("c hold lane", 32'(out_lane_o), 0);
            if (k < 3) begin
                expect_eq("c fill start", 32'(lane_start_o), 32'(2 << k));
            end
            tick();
        end
        pkt_valid_i = 1'b0;
        #2;
        expect_eq("c inflight", 32'(inflight_o), 4);

        // Retire of lane 0 alongside a request: grant only next cycle.
        out_ready_i = 1'b1;
        pkt_valid_i = 1'b1;
        #2;
        expect_eq("d same valid", 32'(out_valid_o), 1);
        expect_eq("d same ready", 32'(pkt_ready_o), 0);
        expect_eq("d same start", 32'(lane_start_o), 0);
        tick();
        grant_cycle("d next", 4'b0001, 2'd0);
        pkt_valid_i = 1'b0;
        #2;
        expect_eq("d c9 valid", 32'(out_valid_o), 0);
        tick();
        lane_ready_i = 4'b1111;
        #2;
        tick();
        lane_ready_i = 4'b0000;
        retire_seq("d", d_seq);
        #2;
        expect_eq("d inflight", 32'(inflight_o), 0);
        tick();

        // Reconfiguration with lanes 1 and 2 in flight.
        grant_cycle("e0", 4'b0010, 2'd1);
        grant_cycle("e1", 4'b0100, 2'd2);
        mod_req_i = 1'b1;
        #2;
        expect_eq("e2 ready", 32'(pkt_ready_o), 0);
        expect_eq("e2 start", 32'(lane_start_o), 0);
        tick();
        #2;
        expect_eq("e3 ready", 32'(pkt_ready_o), 0);
        expect_eq("e3 mod_start", 32'(lane_mod_start_o), 0);
        tick();
        pkt_valid_i = 1'b0;
        lane_ready_i = 4'b0110;
        #2;
        expect_eq("e4 mod_start", 32'(lane_mod_start_o), 0);
        tick();
        #2;
        expect_eq("e5 valid", 32'(out_valid_o), 1);
        expect_eq("e5 lane", 32'(out_lane_o), 1);
        tick();
        mod_req_i = 1'b0;
        lane_ready_i = 4'b0000;
        #2;
        expect_eq("e6 ready", 32'(pkt_ready_o), 0);
        expect_eq("e6 valid", 32'(out_valid_o), 0);
        tick();
        #2;
        expect_eq("e7 lane", 32'(out_lane_o), 2);
        expect_eq("e7 mod_start", 32'(lane_mod_start_o), 0);
        tick();
        #2;
        expect_eq("e8 mod_start", 32'(lane_mod_start_o), 32'hf);
        expect_eq("e8 ack", 32'(mod_ack_o), 0);
        expect_eq("e8 ready", 32'(pkt_ready_o), 0);
        tick();
        #2;
        expect_eq("e9 mod_start", 32'(lane_mod_start_o), 0);
        expect_eq("e9 ack", 32'(mod_ack_o), 1);
        expect_eq("e9 ready", 32'(pkt_ready_o), 0);
        tick();
        grant_cycle("e10", 4'b1000, 2'd3);
        expect_eq("e10 ack", 32'(mod_ack_o), 0);

        // Reset with three lanes busy and the head done.
        grant_cycle("f0", 4'b0001, 2'd0);
        grant_cycle("f1", 4'b0010, 2'd1);
        pkt_valid_i = 1'b0;
        lane_ready_i = 4'b1000;
        out_ready_i = 1'b0;
        tick();
        lane_ready_i = 4'b0000;
        #2;
        expect_eq("f valid", 32'(out_valid_o), 1);
        expect_eq("f lane", 32'(out_lane_o), 3);
        expect_eq("f inflight", 32'(inflight_o), 3);
        tick();
        rst = 1'b1;
        tick();
        #2;
        all_zero("f rst");
        tick();
        rst = 1'b0;
        grant_cycle("f new", 4'b0001, 2'd0);
        pkt_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            expect_eq("f abandon valid", 32'(out_valid_o), 0);
            tick();
        end
        #2;
        expect_eq("f new inflight", 32'(inflight_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_lane_dispatch.md
Name: exec_lane_dispatch

Overview:
- Scheduler in front of NUM_LANES parallel executor instances.
- Grants each incoming matched packet to a free executor lane, tracks lane completion, and retires packets to egress strictly in arrival order.
- Sequences action-table reconfiguration: stops admission, drains all lanes, then pulses a broadcast mod start to every lane.

Parameters:
- NUM_LANES, 4: number of executor lanes; power of two, at least 2.
- LANE_W, 2: log2(NUM_LANES); width of lane indices.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pkt_valid_i  in  1  packet header, match result and out_port are stable at the lane inputs this cycle
- pkt_ready_o  out  1  combinational; transfer occurs when pkt_valid_i && pkt_ready_o
- lane_start_o  out  NUM_LANES  combinational one-hot start to the granted lane, asserted only in the transfer cycle
- lane_sel_o  out  LANE_W  combinational index of the granted lane, for the upstream data mux
- lane_ready_i  in  NUM_LANES  per-lane executor ready_o (level)
- out_valid_o  out  1  registered; head-of-order packet has finished executing
- out_lane_o  out  LANE_W  registered; lane holding that packet, for the egress mux
- out_ready_i  in  1  egress accepts; retire occurs when out_valid_o && out_ready_i
- mod_req_i  in  1  level request to reconfigure; held high until mod_ack_o
- lane_mod_start_o  out  NUM_LANES  registered broadcast mod start, all bits high for exactly 1 cycle
- mod_ack_o  out  1  registered 1-cycle pulse, asserted the cycle after lane_mod_start_o
- inflight_o  out  LANE_W+1  registered count of busy lanes

Behaviour:
- Reset: all outputs 0, including the combinational ones (busy is empty). State RUN, busy[] and done[] cleared, order FIFO empty, rr_ptr = 0. A reset mid-operation abandons in-flight packets; no out_valid_o is issued for them.
- Lane states:
  - busy[i] is set on the transfer edge to lane i and cleared on retire of lane i.
  - done[i] is set on any edge where busy[i] && lane_ready_i[i] && !done[i]; it is cleared on retire.
  - The executor drops ready the same edge it accepts start, so lane_ready_i needs no masking.
  - A lane stays busy after done until retired, because its pkt_hdr_o is held only until its next start.
- Grant: round-robin. Pick the first lane with !busy, scanning from rr_ptr upward mod NUM_LANES. On transfer, rr_ptr <= granted + 1, wrapping.
- pkt_ready_o = (state == RUN) && !mod_req_i && (some lane !busy).
- Order FIFO:
  - Depth NUM_LANES, entries LANE_W wide; it cannot overflow because entries never exceed busy lanes.
  - Push the granted lane on transfer; pop on retire.
- Egress:
  - out_valid_o is registered high when the FIFO is non-empty and done[head] is set, with out_lane_o = head.
  - Minimum latency from a lane's ready rising to out_valid_o is 1 cycle.
  - out_valid_o/out_lane_o must hold while !out_ready_i.
  - After a retire, deassert for at least the next cycle, then re-evaluate against the new head. Back-to-back retires therefore occur at most every 2 cycles.
- Simultaneous events:
  - Transfer and retire in the same cycle are both applied. The retiring lane is not grantable that cycle; it is grantable the next cycle.
  - done set and retire never coincide on the same lane.
- inflight_o equals popcount(busy), registered; it updates on the edge after transfer/retire.
- Reconfiguration FSM, states RUN, DRAIN, MOD, ACK:
  - RUN: mod_req_i -> DRAIN.
  - DRAIN: no admission. When busy == 0 (all retired, FIFO empty) -> MOD; if already empty, next cycle.
  - MOD: lane_mod_start_o = all ones for 1 cycle -> ACK.
  - ACK: mod_ack_o = 1 for 1 cycle -> RUN.
  - Upstream drives mod data to all lanes from MOD through ACK.
  - mod_req_i dropping before ACK is ignored once DRAIN is entered.
- mod_req_i and pkt_valid_i high in the same cycle: mod wins, and no transfer occurs.

Test Plan:
- Reset, then 4 packets back-to-back with all lanes idle -> lane_start_o = 0001, 0010, 0100, 1000 in consecutive cycles; pkt_ready_o = 0 on the 5th cycle; inflight_o = 4.
- Lanes complete out of order (lane 2 ready at t=10, lane 0 at t=15, out_ready_i held 1) -> nothing retires before t=16; then retires lane0, lane1, lane2, lane3 in order, after each lane's ready.
- out_ready_i held 0 for 5 cycles with head done -> out_valid_o and out_lane_o stable all 5 cycles; no FIFO pop.
- Retire lane 0 in the same cycle as pkt_valid_i with lanes 1-3 busy -> no grant that cycle; the next cycle grants lane 0 and pushes it behind lane 3.
- mod_req_i with 2 lanes in flight -> pkt_ready_o = 0 immediately; lane_mod_start_o = 1111 exactly 1 cycle after the last retire is seen; mod_ack_o the following cycle; pkt_ready_o resumes after ACK.
- Assert rst with 3 lanes busy and 1 done -> the next cycle shows all outputs 0, inflight_o = 0, and the first new packet is granted lane 0.
